// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per frame.
// Hits are served combinationally in IDLE; a miss blocks in FETCH until memory returns the word.
module icache_dm #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        flush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam int IW = $clog2(SETS);
   localparam int TW = 30 - IW;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [SETS-1:0] r_valid;
   logic [TW-1:0]   r_tag  [SETS];
   logic [31:0]     r_data [SETS];
   logic [29:0]     r_addr;
   logic [15:0]     r_hits;
   logic [15:0]     r_miss;

   logic [IW-1:0]   w_idx;
   logic [TW-1:0]   w_tag;
   logic [IW-1:0]   w_fidx;
   logic [TW-1:0]   w_ftag;
   logic            w_match;
   logic            w_hit;
   logic            w_miss;
   logic            w_fill;
   logic            w_unused_boff;

   assign w_idx         = imemaddr[IW+1:2];
   assign w_tag         = imemaddr[31:IW+2];
   assign w_fidx        = r_addr[IW-1:0];
   assign w_ftag        = r_addr[29:IW];
   assign w_match       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_unused_boff = ^imemaddr[1:0];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_valid <= '0;
         r_addr  <= '0;
         r_hits  <= '0;
         r_miss  <= '0;
      end else begin
         r_state <= w_next;
         // Flush wins over a fill completing in the same cycle.
         if (flush) begin
            r_valid <= '0;
         end else if (w_fill) begin
            r_valid[w_fidx] <= 1'b1;
         end
         if (w_miss) begin
            r_addr <= imemaddr[31:2];
            r_miss <= r_miss + 16'd1;
         end
         if (w_hit) begin
            r_hits <= r_hits + 16'd1;
         end
      end
   end

   // Tag and data storage carry no reset; the valid bits guard them.
   always_ff @(posedge CLK) begin
      if (w_fill) begin
         r_tag[w_fidx]  <= w_ftag;
         r_data[w_fidx] <= iload;
      end
   end

   always_comb begin
      w_next = r_state;
      w_hit  = 1'b0;
      w_miss = 1'b0;
      w_fill = 1'b0;
      iREN   = 1'b0;
      case (r_state)
         IDLE: begin
            if (imemREN && !flush) begin
               if (w_match) begin
                  w_hit = 1'b1;
               end else begin
                  w_miss = 1'b1;
                  w_next = FETCH;
               end
            end
         end
         FETCH: begin
            iREN = 1'b1;
            if (flush) begin
               w_next = IDLE;
            end else if (!iwait) begin
               w_fill = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign ihit       = w_hit;
   assign imemload   = w_hit ? r_data[w_idx] : 32'd0;
   assign iaddr      = {r_addr, 2'b00};
   assign hit_count  = r_hits;
   assign miss_count = r_miss;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a word-addressed cache model.
module tb_icache_dm;

   localparam int SETS = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        imemREN = 1'b0;
   logic [31:0] imemaddr = '0;
   logic        flush = 1'b0;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait = 1'b0;
   logic [31:0] iload = '0;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int n_chk  = 0;
   int n_pass = 0;

   icache_dm #(.SETS(SETS)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 CLK = ~CLK;

   // Model: each frame remembers the full word address it holds.
   bit          m_fetch;
   bit [29:0]   m_pend;
   bit          m_valid [SETS];
   bit [29:0]   m_word  [SETS];
   bit [31:0]   m_data  [SETS];
   int          m_hits, m_miss;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      m_fetch = 0;
      m_pend  = '0;
      m_hits  = 0;
      m_miss  = 0;
      for (int i = 0; i < SETS; i++) m_valid[i] = 0;
   endtask

   task automatic drive(input bit ren, input logic [31:0] addr, input bit fl,
                        input bit iw, input logic [31:0] ld);
      imemREN  = ren;
      imemaddr = addr;
      flush    = fl;
      iwait    = iw;
      iload    = ld;
      #3;
   endtask

   // Compare this cycle's outputs to the model, then advance the model across the edge.
   task automatic step();
      bit [29:0] word;
      int        idx;
      bit        hit;
      word = imemaddr[31:2];
      idx  = int'(word % SETS);
      hit  = !m_fetch && imemREN && !flush && m_valid[idx] && (m_word[idx] == word);
      chk("ihit",       {31'd0, ihit}, {31'd0, hit});
      chk("imemload",   imemload, hit ? m_data[idx] : 32'd0);
      chk("iREN",       {31'd0, iREN}, {31'd0, m_fetch});
      chk("iaddr",      iaddr, {m_pend, 2'b00});
      chk("hit_count",  {16'd0, hit_count},  m_hits & 32'hFFFF);
      chk("miss_count", {16'd0, miss_count}, m_miss & 32'hFFFF);
      if (m_fetch) begin
         if (!flush && !iwait) begin
            m_valid[m_pend % SETS] = 1;
            m_word[m_pend % SETS]  = m_pend;
            m_data[m_pend % SETS]  = iload;
         end
         if (flush || !iwait) m_fetch = 0;
      end else if (imemREN && !flush && !hit) begin
         m_pend  = word;
         m_fetch = 1;
         m_miss++;
      end
      if (hit) m_hits++;
      if (flush) for (int i = 0; i < SETS; i++) m_valid[i] = 0;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      drive(0, 32'd0, 0, 0, 32'd0);
      chk("rst_iREN", {31'd0, iREN}, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      chk("rst_imemload", imemload, 32'd0);
      chk("rst_miss", {16'd0, miss_count}, 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();
   endtask

   // Miss on addr, wait 'waits' cycles, then deliver data.
   task automatic fill(input logic [31:0] addr, input logic [31:0] data, input int waits);
      drive(1, addr, 0, 1, 32'd0); step();
      for (int i = 0; i < waits; i++) begin
         drive(1, addr, 0, 1, 32'd0); step();
      end
      drive(1, addr, 0, 0, data); step();
   endtask

   initial begin
      model_reset();
      do_reset();

      // Cold miss with three wait cycles.
      drive(1, 32'h40, 0, 1, 32'd0);
      chk("cold_ihit0", {31'd0, ihit}, 32'd0);
      step();
      chk("cold_miss1", {16'd0, miss_count}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h40, 0, 1, 32'd0);
         chk("cold_iREN", {31'd0, iREN}, 32'd1);
         chk("cold_iaddr", iaddr, 32'h40);
         step();
      end
      drive(1, 32'h40, 0, 0, 32'h20010005);
      chk("cold_iREN4", {31'd0, iREN}, 32'd1);
      chk("cold_iaddr4", iaddr, 32'h40);
      step();
      drive(1, 32'h40, 0, 1, 32'd0);
      chk("cold_ihit", {31'd0, ihit}, 32'd1);
      chk("cold_load", imemload, 32'h20010005);
      chk("cold_iREN_off", {31'd0, iREN}, 32'd0);
      step();
      chk("cold_hits1", {16'd0, hit_count}, 32'd1);
      chk("cold_miss_still1", {16'd0, miss_count}, 32'd1);

      // Conflict on index 0.
      do_reset();
      fill(32'h0, 32'hAAAA0000, 0);
      drive(1, 32'h0, 0, 1, 32'd0);
      chk("conf_hit0", imemload, 32'hAAAA0000);
      step();
      fill(32'h40, 32'hBBBB0040, 1);
      drive(1, 32'h40, 0, 1, 32'd0);
      chk("conf_hit40", imemload, 32'hBBBB0040);
      step();
      drive(1, 32'h0, 0, 1, 32'd0);
      chk("conf_evicted", {31'd0, ihit}, 32'd0);
      step();
      chk("conf_miss3", {16'd0, miss_count}, 32'd3);
      drive(1, 32'h0, 0, 0, 32'hCCCC0000); step();

      // Flush in IDLE.
      fill(32'h4, 32'h12345678, 0);
      drive(1, 32'h4, 1, 1, 32'd0);
      chk("flush_suppress", {31'd0, ihit}, 32'd0);
      step();
      drive(1, 32'h4, 0, 1, 32'd0);
      chk("flush_gone", {31'd0, ihit}, 32'd0);
      step();
      chk("flush_refetch", {31'd0, iREN}, 32'd1);
      drive(1, 32'h4, 0, 0, 32'h12345678); step();

      // Flush coinciding with data return.
      drive(1, 32'h8, 0, 1, 32'd0); step();
      drive(1, 32'h8, 1, 0, 32'hDEADBEEF); step();
      drive(1, 32'h8, 0, 1, 32'd0);
      chk("ff_idle", {31'd0, iREN}, 32'd0);
      chk("ff_nowrite", {31'd0, ihit}, 32'd0);
      step();
      drive(1, 32'h8, 0, 0, 32'h88888888); step();

      // Redirect while fetching.
      drive(1, 32'h18, 0, 1, 32'd0); step();
      for (int i = 0; i < 2; i++) begin
         drive(1, 32'h100, 0, 1, 32'd0);
         chk("redir_iaddr", iaddr, 32'h18);
         step();
      end
      drive(1, 32'h100, 0, 0, 32'h0000F018); step();
      drive(1, 32'h100, 0, 1, 32'd0);
      chk("redir_miss", {31'd0, ihit}, 32'd0);
      step();
      chk("redir_newaddr", iaddr, 32'h100);
      drive(1, 32'h18, 0, 0, 32'h11110100); step();
      drive(1, 32'h18, 0, 1, 32'd0);
      chk("redir_18_filled", imemload, 32'h0000F018);
      step();

      // Asynchronous reset mid-fetch.
      drive(1, 32'h200, 0, 1, 32'd0); step();
      drive(1, 32'h200, 0, 1, 32'd0);
      RST = 1'b1;
      #1;
      chk("arst_iREN", {31'd0, iREN}, 32'd0);
      chk("arst_ihit", {31'd0, ihit}, 32'd0);
      chk("arst_hits", {16'd0, hit_count}, 32'd0);
      chk("arst_miss", {16'd0, miss_count}, 32'd0);
      #2;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();

      // Randomized traffic over a small footprint so hits, conflicts and waits all occur.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         a = {22'd0, 8'($urandom_range(0, 47)), 2'($urandom_range(0, 3))};
         drive(($urandom_range(0, 9) < 8), a, ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 1) == 1), $urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
